// File: rtl/axis_pipe_stage.sv
// rtl/axis_pipe_stage.sv - valid/last/data register slice with advance enable and sync reset
module axis_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             valid_in,
    input  logic             last_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic             last_out,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_q, valid_d;
    logic             last_q,  last_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (en_in) begin
            valid_d = valid_in;
            last_d  = last_in;
            data_d  = data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign data_out  = data_q;

endmodule

// File: rtl/power_spectrum.sv
// rtl/power_spectrum.sv - streaming |X|^2 of complex FFT bins, two-stage pipeline with backpressure
module power_spectrum #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [2*DATA_WIDTH-1:0] fft_data_in,
    input  logic                    fft_valid_in,
    input  logic                    fft_last_in,
    output logic                    fft_ready_out,
    input  logic                    power_ready_in,
    output logic                    power_valid_out,
    output logic                    power_last_out,
    output logic [2*DATA_WIDTH-1:0] power_data_out
);

    localparam int OUT_W = 2 * DATA_WIDTH;
    localparam int SQ_W  = 2 * DATA_WIDTH - 1;

    logic                   adv;
    logic signed [DATA_WIDTH-1:0] re, im;
    logic signed [SQ_W-1:0] re_x, im_x;
    logic        [SQ_W-1:0] re_sq, im_sq;

    logic                   s1_valid, s1_last;
    logic [2*SQ_W-1:0]      s1_data;
    logic [OUT_W-1:0]       sum;

    // Single global enable: the whole pipe moves or the whole pipe holds.
    assign adv           = !power_valid_out || power_ready_in;
    assign fft_ready_out = adv && !rst_in;

    assign re   = fft_data_in[OUT_W-1:DATA_WIDTH];
    assign im   = fft_data_in[DATA_WIDTH-1:0];
    assign re_x = SQ_W'(re);
    assign im_x = SQ_W'(im);

    // A square of a signed value is non-negative; the low SQ_W bits read
    // as unsigned hold it exactly, including (-2^(W-1))^2.
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;

    axis_pipe_stage #(.WIDTH(2 * SQ_W)) u_stage1 (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (adv),
        .valid_in  (fft_valid_in && fft_ready_out),
        .last_in   (fft_last_in),
        .data_in   ({re_sq, im_sq}),
        .valid_out (s1_valid),
        .last_out  (s1_last),
        .data_out  (s1_data)
    );

    assign sum = {1'b0, s1_data[2*SQ_W-1:SQ_W]} + {1'b0, s1_data[SQ_W-1:0]};

    axis_pipe_stage #(.WIDTH(OUT_W)) u_stage2 (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (adv),
        .valid_in  (s1_valid),
        .last_in   (s1_last),
        .data_in   (sum),
        .valid_out (power_valid_out),
        .last_out  (power_last_out),
        .data_out  (power_data_out)
    );

endmodule

// File: tb/tb_power_spectrum.sv
// tb/tb_power_spectrum.sv - directed-vector and scoreboard bench for power_spectrum
module tb_power_spectrum;

    localparam int DW = 16;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [2*DW-1:0]   fft_data_in;
    logic              fft_valid_in;
    logic              fft_last_in;
    logic              fft_ready_out;
    logic              power_ready_in;
    logic              power_valid_out;
    logic              power_last_out;
    logic [2*DW-1:0]   power_data_out;

    logic signed [DW-1:0] drv_re, drv_im;
    assign fft_data_in = {drv_re, drv_im};

    always #5 clk_in = ~clk_in;

    power_spectrum #(.DATA_WIDTH(DW)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .fft_data_in     (fft_data_in),
        .fft_valid_in    (fft_valid_in),
        .fft_last_in     (fft_last_in),
        .fft_ready_out   (fft_ready_out),
        .power_ready_in  (power_ready_in),
        .power_valid_out (power_valid_out),
        .power_last_out  (power_last_out),
        .power_data_out  (power_data_out)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
        longint a;
        longint b;
        a = r;
        b = i;
        return 32'(a * a + b * b);
    endfunction

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    bit   chk_lat = 1'b1;
    int   out_xfers = 0;
    int   in_xfers = 0;
    int   last_seen = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Scoreboard: inputs are pushed as they are accepted, outputs popped as they are taken.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in) begin
            sb.delete();
        end else begin
            if (power_valid_out && power_ready_in) begin
                out_xfers++;
                if (power_last_out) last_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", 64'(power_data_out), 64'(e.data));
                    chk("sb_last", 64'(power_last_out), 64'(e.last));
                    if (chk_lat) chk("sb_latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
            if (fft_valid_in && fft_ready_out) begin
                in_xfers++;
                e.data = model(drv_re, drv_im);
                e.last = fft_last_in;
                e.cyc  = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain();
        fft_valid_in   = 1'b0;
        power_ready_in = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic [31:0]          exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int i0;
        int o0;
        int l0;
        int pat[5];
        bit b;

        tbl[0] = '{-16'sd16384, 16'sd0,     32'd268435456};
        tbl[1] = '{-16'sd64,    16'sd0,     32'd4096};
        tbl[2] = '{16'sd0,      16'sd0,     32'd0};
        tbl[3] = '{16'sd3,      16'sd4,     32'd25};
        tbl[4] = '{16'sd1533,   16'sd2044,  32'd6528025};
        tbl[5] = '{-16'sd32768, -16'sd32768, 32'h8000_0000};
        tbl[6] = '{-16'sd8192,  16'sd8191,  32'd134201345};
        tbl[7] = '{16'sd32767,  16'sd32767, 32'd2147352578};
        tbl[8] = '{-16'sd1,     16'sd1,     32'd2};

        rst_in = 1'b1;
        fft_valid_in = 1'b0;
        fft_last_in = 1'b0;
        power_ready_in = 1'b1;
        drv_re = '0;
        drv_im = '0;

        step();
        step();
        chk("rst_valid", 64'(power_valid_out), 64'd0);
        chk("rst_last",  64'(power_last_out),  64'd0);
        chk("rst_data",  64'(power_data_out),  64'd0);
        chk("rst_ready", 64'(fft_ready_out),   64'd0);
        rst_in = 1'b0;
        #1;
        chk("post_rst_ready", 64'(fft_ready_out), 64'd1);

        // Directed table, back to back; output k-1 is visible after edge k.
        for (int k = 0; k <= 9; k++) begin
            if (k < 9) begin
                drv_re = tbl[k].re;
                drv_im = tbl[k].im;
                fft_valid_in = 1'b1;
            end else begin
                fft_valid_in = 1'b0;
            end
            step();
            if (k >= 1) begin
                chk("tbl_valid", 64'(power_valid_out), 64'd1);
                chk("tbl_data",  64'(power_data_out),  64'(tbl[k-1].exp));
            end
        end
        drain();

        o0 = out_xfers;
        for (int v = -16384; v <= 16320; v += 64) begin
            drv_re = 16'(v);
            drv_im = '0;
            fft_valid_in = 1'b1;
            step();
        end
        drain();
        chk("real_sweep_count", 64'(out_xfers - o0), 64'd512);

        o0 = out_xfers;
        for (int v = -16384; v <= 16320; v += 64) begin
            drv_re = '0;
            drv_im = 16'(v);
            fft_valid_in = 1'b1;
            step();
        end
        drain();
        chk("imag_sweep_count", 64'(out_xfers - o0), 64'd512);

        o0 = out_xfers;
        for (int i = 0; i < 512; i++) begin
            drv_re = 16'(3 * i);
            drv_im = 16'(4 * i);
            fft_valid_in = 1'b1;
            step();
        end
        drain();
        chk("mixed_sweep_count", 64'(out_xfers - o0), 64'd512);

        // Backpressure hold.
        chk_lat = 1'b0;
        power_ready_in = 1'b0;
        drv_re = -16'sd8192;
        drv_im = 16'sd8191;
        fft_valid_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k >= 1) begin
                chk("bp_valid", 64'(power_valid_out), 64'd1);
                chk("bp_data",  64'(power_data_out),  64'd134201345);
                chk("bp_ready", 64'(fft_ready_out),   64'd0);
            end
        end
        pat = '{1, 0, 1, 1, 0};
        for (int k = 0; k < 4; k++) begin
            power_ready_in = (k != 1);
            x0 = out_xfers;
            step();
            chk("bp_xfer", 64'(out_xfers - x0), 64'(k != 1));
        end
        drain();
        chk_lat = 1'b1;

        // Valid gaps with ready held high.
        for (int k = 0; k < 6; k++) begin
            fft_valid_in = (k < 5) ? pat[k][0] : 1'b0;
            drv_re = 16'(k + 1);
            drv_im = '0;
            step();
            if (k >= 1) chk("gap_valid", 64'(power_valid_out), 64'(pat[k-1]));
        end
        drain();

        // Valid and ready toggling together.
        chk_lat = 1'b0;
        i0 = in_xfers;
        o0 = out_xfers;
        for (int k = 0; k < 20; k++) begin
            b = (k % 3) != 1;
            fft_valid_in = b;
            power_ready_in = b;
            drv_re = 16'(100 + k);
            drv_im = 16'(-k);
            step();
        end
        drain();
        chk("lockstep_count", 64'(out_xfers - o0), 64'(in_xfers - i0));
        chk_lat = 1'b1;

        // Reset mid-stream discards in-flight samples.
        for (int k = 0; k < 3; k++) begin
            drv_re = 16'(500 + k);
            drv_im = 16'sd7;
            fft_valid_in = 1'b1;
            step();
        end
        rst_in = 1'b1;
        #1;
        chk("midrst_ready", 64'(fft_ready_out), 64'd0);
        step();
        chk("midrst_valid", 64'(power_valid_out), 64'd0);
        chk("midrst_last",  64'(power_last_out),  64'd0);
        chk("midrst_data",  64'(power_data_out),  64'd0);
        chk("midrst_ready2", 64'(fft_ready_out),  64'd0);
        rst_in = 1'b0;
        fft_valid_in = 1'b0;
        step();
        chk("midrst_empty_valid", 64'(power_valid_out), 64'd0);

        // Last flag on the 4th sample only.
        l0 = last_seen;
        for (int k = 0; k < 6; k++) begin
            drv_re = 16'(10 * k);
            drv_im = 16'(k);
            fft_last_in = (k == 3);
            fft_valid_in = 1'b1;
            step();
            if (k >= 1) chk("last_pos", 64'(power_last_out), 64'(k - 1 == 3));
        end
        fft_last_in = 1'b0;
        drain();
        chk("last_count", 64'(last_seen - l0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/power_spectrum.md
Name: power_spectrum

Overview:
- Streaming complex-magnitude-squared block: converts each FFT bin {real, imag} into power = real^2 + imag^2.
- Sits between the FFT core's AXI-Stream-style output and downstream spectrum consumers.
- Fully pipelined at one sample per clock, with valid/ready backpressure and a frame "last" flag propagated alongside the data.

Parameters:
- DATA_WIDTH, 16, width of each signed component (real, imag); the output width is 2*DATA_WIDTH.

Ports:
- clk_in  input  1  system clock, all logic on its rising edge
- rst_in  input  1  reset, synchronous, active-high
- fft_data_in  input  2*DATA_WIDTH  {real[31:16], imag[15:0]}, both two's-complement signed
- fft_valid_in  input  1  input sample valid
- fft_last_in  input  1  input sample is the last bin of the frame
- fft_ready_out  output  1  block can accept an input this cycle
- power_ready_in  input  1  downstream accepts an output this cycle
- power_valid_out  output  1  power_data_out is valid
- power_last_out  output  1  last flag aligned with power_data_out
- power_data_out  output  2*DATA_WIDTH  unsigned real^2 + imag^2

Behaviour:
- Handshake rules:
  - A transfer occurs on a cycle where valid && ready are both high, on each side independently.
  - Producer and consumer may raise or drop valid/ready arbitrarily.
  - A valid output holds data and last stable until accepted.
- Pipeline:
  - Two register stages. Stage 1 registers re^2 and im^2 plus valid and last. Stage 2 registers their sum plus valid and last; stage 2 drives the outputs.
- Advance and stall:
  - Global advance enable adv = !power_valid_out || power_ready_in.
  - While adv is low, all stages hold (data, valid and last).
  - fft_ready_out = adv && !rst_in (combinational).
- Latency and throughput:
  - An input accepted in cycle N appears on the outputs in cycle N+2 when there is no backpressure.
  - Throughput is 1 sample per clock with ready held high.
- Bubbles: a cycle with adv high and no input transfer shifts a bubble (valid=0) into stage 1. Bubbles are not collapsed while stalled.
- Arithmetic:
  - Each square is a signed x signed product, width 2*DATA_WIDTH-1 magnitude, always non-negative.
  - The sum is computed at 2*DATA_WIDTH bits unsigned, with no truncation, rounding or saturation.
  - Worst case (-32768, -32768) gives 2^31 = 0x8000_0000, which fits.
- Last flag: fft_last_in is captured with its sample and travels with it unmodified. No frame counting is done.
- Reset (synchronous, takes priority over every other event):
  - All valid bits, last bits and data registers clear to 0, so power_valid_out=0, power_last_out=0, power_data_out=0.
  - fft_ready_out=0 during reset and returns to 1 on the first cycle after reset.
  - In-flight samples are discarded if reset is asserted mid-stream.
- Simultaneous events: in a cycle with an output accept and an input accept together, the pipeline shifts normally with no loss or duplication.
- Idle inputs: fft_data_in and fft_last_in are ignored when fft_valid_in=0 (stage 1 loads valid=0; its data may still update).

Decomposition:
- No shared package needed. DATA_WIDTH is a local parameter; output width is derived as 2*DATA_WIDTH.
- One natural sub-module: axis_pipe_stage, a parameterised valid/last/data register with enable and sync reset, instantiated twice. The squaring and addition are inline in the parent.

Test Plan:
- Purely real sweep: ready=1, imag=0, real from -16384 to 16320 step 64, one per clock.
  - Outputs arrive 2 cycles after each input: -16384 -> 268435456 (0x1000_0000), -64 -> 4096, 0 -> 0.
  - The output stream has no gaps or duplicates.
- Purely imaginary sweep: same values on imag with real=0 -> identical power sequence to the real sweep.
- Both components, real=3i and imag=4i for i=0..511 -> power=25*i^2. Checks: i=1 gives 25, i=511 gives 6528025. Sign-extremes check: (-32768, -32768) gives 0x8000_0000.
- Backpressure hold:
  - Inputs: real=-8192, imag=8191, valid=1, with power_ready_in=0 for 10 cycles.
  - Expected: power_valid_out rises with data 134201345 and holds stable, and fft_ready_out=0 once stage 2 is full.
  - Then toggle ready 1,0,1,1 and check one transfer per ready-high cycle.
- Valid gaps with ready=1:
  - Stimulus: toggle fft_valid_in 1,0,1,1,0.
  - Expected: output valid follows the same 1,0,1,1,0 pattern delayed by 2 cycles.
  - Repeat with valid and ready toggling in lockstep and confirm no lost or duplicated samples.
- Reset and last:
  - Assert rst_in mid-stream -> next cycle all outputs are 0 and fft_ready_out=0.
  - After reset, fft_last_in=1 on the 4th sample -> power_last_out=1 only on the 4th output.
